// File: rtl/br_ckpt_ctrl.sv
// br_ckpt_ctrl -- branch checkpoint controller for the global-history
// direction predictor.
//
// Each in-flight branch gets a checkpoint (tag) holding the BHR used for its
// prediction and the predicted direction. Branches resolve out of order. An
// accepted resolve produces one registered PHT update on the next cycle. A
// mispredict squashes every younger checkpoint and produces a one-cycle BHR
// recovery strobe. Checkpoints retire in order from the head, at most one per
// cycle, once they are resolved.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   alloc_valid_i/bhr_i/pred_i  dispatch checkpoint request
//   alloc_ready_o, alloc_tag_o  checkpoint free / tag given on handshake
//   reslv_valid_i/tag_i/taken_i branch resolution
//   flush_i                     full pipeline flush (highest priority)
//   upd_valid_o/bhr_o/taken_o   PHT update, one cycle after resolve
//   recov_valid_o/bhr_o         BHR recovery, one cycle after mispredict
//   count_o                     live checkpoints
//
// Optional: define BR_CKPT_STATS_EN to add reslv_cnt_o / mispred_cnt_o,
// free-running counters of accepted resolves and mispredicts.
module br_ckpt_ctrl #(
  parameter int BHR_W = 8,
  parameter int TAG_W = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid_i,
  input  logic [BHR_W-1:0] alloc_bhr_i,
  input  logic             alloc_pred_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             reslv_valid_i,
  input  logic [TAG_W-1:0] reslv_tag_i,
  input  logic             reslv_taken_i,
  input  logic             flush_i,
  output logic             upd_valid_o,
  output logic [BHR_W-1:0] upd_bhr_o,
  output logic             upd_taken_o,
  output logic             recov_valid_o,
  output logic [BHR_W-1:0] recov_bhr_o,
  output logic [TAG_W:0]   count_o
`ifdef BR_CKPT_STATS_EN
  ,
  output logic [31:0]      reslv_cnt_o,
  output logic [31:0]      mispred_cnt_o
`endif
);

  typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  // Corrected history: the mispredicted branch's real outcome shifted in.
  function automatic logic [BHR_W-1:0] fix_hist(input logic [BHR_W-1:0] bhr,
                                                input logic taken);
    return {bhr[BHR_W-2:0], taken};
  endfunction

  state_t           state;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_pred;
  logic [BHR_W-1:0] ent_bhr [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic             upd_vld_p1;
  logic [BHR_W-1:0] upd_bhr_p1;
  logic             upd_taken_p1;
  logic             recov_vld_p1;
  logic [BHR_W-1:0] recov_bhr_p1;

  logic             res_acc;
  logic             mispred;
  logic             retire;
  logic             alloc_wr;
  logic [TAG_W-1:0] res_off;
  logic [DEPTH-1:0] younger;
  logic [TAG_W:0]   count_nxt;

  assign alloc_ready_o = (count != (TAG_W+1)'(DEPTH)) && (state == NORMAL);
  assign alloc_tag_o   = tail;
  assign count_o       = count;

  always_comb begin
    res_acc  = reslv_valid_i && ent_vld[reslv_tag_i] && !ent_done[reslv_tag_i] && !flush_i;
    mispred  = res_acc && (reslv_taken_i != ent_pred[reslv_tag_i]);
    retire   = ent_vld[head] && ent_done[head];
    // A same-cycle mispredict squashes the new branch, so it is never written.
    alloc_wr = alloc_valid_i && alloc_ready_o && !flush_i && !mispred;
    // Age is measured as distance from head, which makes wrap-around free.
    res_off  = reslv_tag_i - head;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = (TAG_W'(i) - head) > res_off;
    end
    if (mispred) begin
      count_nxt = {1'b0, res_off} + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
    end else begin
      count_nxt = count + (TAG_W+1)'(alloc_wr) - (TAG_W+1)'(retire);
    end
  end

  // Stage p0 -> p1: checkpoint bookkeeping, FSM and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NORMAL;
      ent_vld      <= '0;
      ent_done     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      upd_vld_p1   <= 1'b0;
      upd_bhr_p1   <= '0;
      upd_taken_p1 <= 1'b0;
      recov_vld_p1 <= 1'b0;
      recov_bhr_p1 <= '0;
    end else if (flush_i) begin
      state        <= NORMAL;
      ent_vld      <= '0;
      ent_done     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      upd_vld_p1   <= 1'b0;
      recov_vld_p1 <= 1'b0;
    end else begin
      if (retire) begin
        ent_vld[head]  <= 1'b0;
        ent_done[head] <= 1'b0;
        head           <= head + TAG_W'(1);
      end
      if (res_acc) begin
        ent_done[reslv_tag_i] <= 1'b1;
        upd_bhr_p1            <= ent_bhr[reslv_tag_i];
        upd_taken_p1          <= reslv_taken_i;
      end
      if (mispred) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (younger[i]) begin
            ent_vld[i]  <= 1'b0;
            ent_done[i] <= 1'b0;
          end
        end
        tail         <= reslv_tag_i + TAG_W'(1);
        recov_bhr_p1 <= fix_hist(ent_bhr[reslv_tag_i], reslv_taken_i);
        state        <= RECOVER;
      end else begin
        // RECOVER lasts exactly one cycle unless a new mispredict restarts it.
        state <= NORMAL;
        if (alloc_wr) begin
          ent_vld[tail]  <= 1'b1;
          ent_done[tail] <= 1'b0;
          tail           <= tail + TAG_W'(1);
        end
      end
      count        <= count_nxt;
      upd_vld_p1   <= res_acc;
      recov_vld_p1 <= mispred;
    end
  end

  // Checkpoint payload: only read while the entry is valid.
  always_ff @(posedge clk) begin
    if (alloc_wr) begin
      ent_bhr[tail]  <= alloc_bhr_i;
      ent_pred[tail] <= alloc_pred_i;
    end
  end

  assign upd_valid_o   = upd_vld_p1;
  assign upd_bhr_o     = upd_bhr_p1;
  assign upd_taken_o   = upd_taken_p1;
  assign recov_valid_o = recov_vld_p1;
  assign recov_bhr_o   = recov_bhr_p1;

`ifdef BR_CKPT_STATS_EN
  // Statistics survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reslv_cnt_o   <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (res_acc) reslv_cnt_o <= reslv_cnt_o + 32'd1;
      if (mispred) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_ckpt_ctrl.sv
// Self-checking bench for br_ckpt_ctrl: directed scenarios followed by
// random traffic, all compared against an age-ordered queue model.
module tb_br_ckpt_ctrl;
  localparam int BHR_W = 8;
  localparam int TAG_W = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_valid_i;
  logic [BHR_W-1:0] alloc_bhr_i;
  logic             alloc_pred_i;
  logic             alloc_ready_o;
  logic [TAG_W-1:0] alloc_tag_o;
  logic             reslv_valid_i;
  logic [TAG_W-1:0] reslv_tag_i;
  logic             reslv_taken_i;
  logic             flush_i;
  logic             upd_valid_o;
  logic [BHR_W-1:0] upd_bhr_o;
  logic             upd_taken_o;
  logic             recov_valid_o;
  logic [BHR_W-1:0] recov_bhr_o;
  logic [TAG_W:0]   count_o;
`ifdef BR_CKPT_STATS_EN
  logic [31:0]      reslv_cnt_o;
  logic [31:0]      mispred_cnt_o;
`endif

  always #5 clk = ~clk;

  br_ckpt_ctrl #(.BHR_W(BHR_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_bhr_i(alloc_bhr_i), .alloc_pred_i(alloc_pred_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .reslv_valid_i(reslv_valid_i), .reslv_tag_i(reslv_tag_i), .reslv_taken_i(reslv_taken_i),
    .flush_i(flush_i),
    .upd_valid_o(upd_valid_o), .upd_bhr_o(upd_bhr_o), .upd_taken_o(upd_taken_o),
    .recov_valid_o(recov_valid_o), .recov_bhr_o(recov_bhr_o), .count_o(count_o)
`ifdef BR_CKPT_STATS_EN
    , .reslv_cnt_o(reslv_cnt_o), .mispred_cnt_o(mispred_cnt_o)
`endif
  );

  // Model: live branches oldest-first; a branch's tag is (m_head + position) mod DEPTH.
  typedef struct { logic [7:0] bhr; bit pred; bit done; } ent_t;
  ent_t        mq[$];
  int          m_head;
  bit          m_recov;
  bit          m_upd_v, m_upd_tk, m_recov_v;
  logic [7:0]  m_upd_bhr, m_recov_bhr;
  int unsigned m_res_cnt, m_mis_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_head = 0; m_recov = 0;
    m_upd_v = 0; m_upd_tk = 0; m_recov_v = 0;
    m_upd_bhr = '0; m_recov_bhr = '0;
    m_res_cnt = 0; m_mis_cnt = 0;
  endtask

  task automatic model_step(input bit fl, input bit av, input logic [7:0] b, input bit p,
                            input bit rv, input logic [2:0] t, input bit tk);
    int k;
    bit rdy, ret, acc, mis;
    ent_t e;
    if (fl) begin
      mq.delete();
      m_head = 0; m_recov = 0; m_upd_v = 0; m_recov_v = 0;
      return;
    end
    rdy = (mq.size() != DEPTH) && !m_recov;
    ret = 0;
    if (mq.size() > 0) ret = mq[0].done;
    k = (int'(t) - m_head + DEPTH) % DEPTH;
    acc = 0; mis = 0;
    if (rv && k < mq.size()) begin
      if (!mq[k].done) acc = 1;
    end
    if (acc) begin
      e = mq[k]; e.done = 1; mq[k] = e;
      m_upd_bhr = e.bhr; m_upd_tk = tk;
      mis = (tk != e.pred);
      m_res_cnt++;
    end
    m_upd_v = acc; m_recov_v = mis;
    if (mis) begin
      m_recov_bhr = {e.bhr[6:0], tk};
      m_mis_cnt++;
      while (mq.size() > k + 1) void'(mq.pop_back());
    end else if (av && rdy) begin
      e.bhr = b; e.pred = p; e.done = 0;
      mq.push_back(e);
    end
    if (ret) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    m_recov = mis;
  endtask

  task automatic check_all(input string ph);
    chk_eq({ph, ".count"}, 32'(count_o), 32'(mq.size()));
    chk_eq({ph, ".ready"}, 32'(alloc_ready_o), 32'((mq.size() != DEPTH) && !m_recov));
    chk_eq({ph, ".tag"}, 32'(alloc_tag_o), 32'((m_head + mq.size()) % DEPTH));
    chk_eq({ph, ".upd_v"}, 32'(upd_valid_o), 32'(m_upd_v));
    chk_eq({ph, ".upd_bhr"}, 32'(upd_bhr_o), 32'(m_upd_bhr));
    chk_eq({ph, ".upd_tk"}, 32'(upd_taken_o), 32'(m_upd_tk));
    chk_eq({ph, ".recov_v"}, 32'(recov_valid_o), 32'(m_recov_v));
    chk_eq({ph, ".recov_bhr"}, 32'(recov_bhr_o), 32'(m_recov_bhr));
`ifdef BR_CKPT_STATS_EN
    chk_eq({ph, ".reslv_cnt"}, reslv_cnt_o, 32'(m_res_cnt));
    chk_eq({ph, ".mispred_cnt"}, mispred_cnt_o, 32'(m_mis_cnt));
`endif
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model,
  // then compare on the next falling edge.
  task automatic cyc(input string ph, input bit fl, input bit av, input logic [7:0] b,
                     input bit p, input bit rv, input logic [2:0] t, input bit tk);
    flush_i = fl; alloc_valid_i = av; alloc_bhr_i = b; alloc_pred_i = p;
    reslv_valid_i = rv; reslv_tag_i = t; reslv_taken_i = tk;
    model_step(fl, av, b, p, rv, t, tk);
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic idle(input string ph);
    cyc(ph, 0, 0, 8'h00, 0, 0, 3'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 0; alloc_valid_i = 0; alloc_bhr_i = '0; alloc_pred_i = 0;
    reslv_valid_i = 0; reslv_tag_i = '0; reslv_taken_i = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    chk_eq("reset.ready_const", 32'(alloc_ready_o), 32'd1);
    rst_n = 1'b1;

    // Fill to full, then back-pressure.
    for (int i = 0; i < DEPTH; i++) cyc("fill", 0, 1, 8'(i + 1), 1, 0, 3'd0, 0);
    chk_eq("fill.count8", 32'(count_o), 32'd8);
    chk_eq("fill.ready0", 32'(alloc_ready_o), 32'd0);
    cyc("fill9", 0, 1, 8'h09, 1, 0, 3'd0, 0);
    chk_eq("fill9.count8", 32'(count_o), 32'd8);

    // Correct resolve out of order; head waits for tags 0 and 1.
    cyc("res2", 0, 0, 8'h00, 0, 1, 3'd2, 1);
    chk_eq("res2.upd_v", 32'(upd_valid_o), 32'd1);
    chk_eq("res2.upd_bhr", 32'(upd_bhr_o), 32'h03);
    chk_eq("res2.recov_v", 32'(recov_valid_o), 32'd0);
    cyc("res0", 0, 0, 8'h00, 0, 1, 3'd0, 1);
    cyc("res1", 0, 0, 8'h00, 0, 1, 3'd1, 1);
    cyc("dbl2", 0, 0, 8'h00, 0, 1, 3'd2, 0);
    chk_eq("dbl2.upd_v", 32'(upd_valid_o), 32'd0);
    idle("drain"); idle("drain");
    cyc("flush", 1, 0, 8'h00, 0, 0, 3'd0, 0);

    // Mispredict at tag 1 of 5 live entries.
    cyc("mp.a0", 0, 1, 8'h10, 1, 0, 3'd0, 0);
    cyc("mp.a1", 0, 1, 8'h5A, 0, 0, 3'd0, 0);
    cyc("mp.a2", 0, 1, 8'h20, 1, 0, 3'd0, 0);
    cyc("mp.a3", 0, 1, 8'h30, 1, 0, 3'd0, 0);
    cyc("mp.a4", 0, 1, 8'h40, 1, 0, 3'd0, 0);
    cyc("mp.res", 0, 1, 8'h77, 1, 1, 3'd1, 1);
    chk_eq("mp.recov_v", 32'(recov_valid_o), 32'd1);
    chk_eq("mp.recov_bhr", 32'(recov_bhr_o), 32'hB5);
    chk_eq("mp.upd_bhr", 32'(upd_bhr_o), 32'h5A);
    chk_eq("mp.count", 32'(count_o), 32'd2);
    chk_eq("mp.ready", 32'(alloc_ready_o), 32'd0);
    idle("mp.after");
    chk_eq("mp.tag2", 32'(alloc_tag_o), 32'd2);
    chk_eq("mp.ready1", 32'(alloc_ready_o), 32'd1);
    cyc("mp.sq3", 0, 0, 8'h00, 0, 1, 3'd3, 1);
    chk_eq("mp.sq3.upd_v", 32'(upd_valid_o), 32'd0);
    cyc("flush2", 1, 0, 8'h00, 0, 0, 3'd0, 0);

    // Wrap-around: move head to 6, then mispredict at tag 7.
    for (int i = 0; i < 6; i++) cyc("wr.alloc", 0, 1, 8'(8'h80 + i), 1, 0, 3'd0, 0);
    for (int i = 0; i < 6; i++) cyc("wr.res", 0, 0, 8'h00, 0, 1, 3'(i), 1);
    for (int i = 0; i < 3; i++) idle("wr.drain");
    chk_eq("wr.tag6", 32'(alloc_tag_o), 32'd6);
    for (int i = 0; i < 4; i++) cyc("wr.alloc2", 0, 1, 8'(8'hC0 + i), 0, 0, 3'd0, 0);
    cyc("wr.mp7", 0, 0, 8'h00, 0, 1, 3'd7, 1);
    chk_eq("wr.mp7.count", 32'(count_o), 32'd2);
    idle("wr.after");
    chk_eq("wr.tag0", 32'(alloc_tag_o), 32'd0);
    cyc("wr.res6", 0, 0, 8'h00, 0, 1, 3'd6, 0);
    idle("wr.ret"); idle("wr.ret");
    cyc("wr.alloc0", 0, 1, 8'hE0, 0, 0, 3'd0, 0);

    // Flush beats a simultaneous mispredict and allocation.
    cyc("fm.a", 0, 1, 8'hE1, 0, 0, 3'd0, 0);
    cyc("fm.a", 0, 1, 8'hE2, 0, 0, 3'd0, 0);
    cyc("fm.flush", 1, 1, 8'hE3, 0, 1, 3'd1, 1);
    chk_eq("fm.count", 32'(count_o), 32'd0);
    chk_eq("fm.recov_v", 32'(recov_valid_o), 32'd0);
    chk_eq("fm.upd_v", 32'(upd_valid_o), 32'd0);
    chk_eq("fm.tag", 32'(alloc_tag_o), 32'd0);

    // Random traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 4000; n++) begin
      bit fl, av, p, rv, tk;
      logic [7:0] b;
      logic [2:0] t;
      if (n == 2000) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      fl = ($urandom % 64) == 0;
      av = ($urandom % 10) < 7;
      b  = 8'($urandom);
      p  = 1'($urandom);
      rv = ($urandom % 2) == 0;
      tk = 1'($urandom);
      if (mq.size() > 0 && ($urandom % 4) != 0)
        t = 3'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
      else
        t = 3'($urandom);
      cyc("rnd", fl, av, b, p, rv, t, tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
